pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard, forwarding and pipeline-enable controller for the 5-stage pipelined core: IF, ID, EX, MEM, WB.
- Resolves EX-stage operands for NRD read ports by forwarding from MEM and WB.
- Inserts load-use bubbles and flushes on taken branches.
- Freezes the pipe on outstanding dcache requests, drains and latches halt, and keeps a saturating stall counter.
- Owns every latch enable and flush in the datapath, as well as the PC enable.

Parameters:
DATA_W, 32, datapath word width
REGS_W, 5, register index width
NRD, 2, operand read ports per instruction
BACK_STAGES, 2, back_go events from halt leaving EX to full drain (MEM, WB)
CNT_W, 16, stall counter width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous active-high reset
ihit  in  1  icache hit
dhit  in  1  dcache hit
id_valid  in  1  ID holds a real instruction
id_rsel  in  NRD*REGS_W  ID source registers
ex_rsel  in  NRD*REGS_W  EX source registers
ex_rdat  in  NRD*DATA_W  EX operands from ID/EX latch
ex_dREN  in  1  EX instruction is a load
ex_WEN  in  1  EX writes register
ex_wsel  in  REGS_W  EX destination
ex_halt  in  1  EX instruction is halt
branch_taken  in  1  EX branch/jump redirects PC
mem_dREN  in  1  MEM load request
mem_dWEN  in  1  MEM store request
mem_WEN  in  1  MEM writes register
mem_wsel  in  REGS_W  MEM destination
mem_port_o  in  DATA_W  MEM ALU result
wb_WEN  in  1  WB writes register
wb_wsel  in  REGS_W  WB destination
wb_wdat  in  DATA_W  WB write data
fwd_rdat  out  NRD*DATA_W  forwarded EX operands
pc_en  out  1  PC update
ifid_en  out  1  IF/ID enable
ifid_flush  out  1  IF/ID bubble
idex_en  out  1  ID/EX enable
idex_flush  out  1  ID/EX bubble
exmem_en  out  1  EX/MEM enable
memwb_en  out  1  MEM/WB enable
halt  out  1  sticky halt, registered
stall_cnt  out  CNT_W  saturating stall counter

Behaviour:

Reset:
- RST is synchronous and active-high, sampled on CLK.
- Reset state: state=RUN, drain_cnt=0, halt=0, stall_cnt=0.
- While RST is high, all enables and flushes are 0.
- RST mid-drain or while HALTED returns the block to RUN.

Forwarding (combinational, per port p):
- Priority order:
  1. rsel==0 -> 0.
  2. mem_WEN && !mem_dREN && mem_wsel==rsel -> mem_port_o.
  3. wb_WEN && wb_wsel==rsel -> wb_wdat.
  4. Otherwise -> ex_rdat.
- MEM takes priority over WB.

Combinational terms:
- mem_req = mem_dREN | mem_dWEN.
- back_go = mem_req ? dhit : ihit.
- load_use = id_valid && ex_dREN && ex_WEN && ex_wsel!=0 && any id_rsel[p]==ex_wsel.
- A load-use condition lasts at most one back_go, because the load then moves to MEM.

State RUN:
- exmem_en = memwb_en = idex_en = back_go.
- If branch_taken && back_go (branch takes priority over load_use):
  - pc_en=1, ifid_flush=1, idex_flush=1, ifid_en=0.
- Else if load_use && back_go:
  - pc_en=0, ifid_en=0, idex_flush=1.
- Else:
  - pc_en = ifid_en = ihit && back_go.
  - ifid_flush = back_go && !ihit.
- If ex_halt && back_go (and not branch_taken): go to DRAIN with drain_cnt=0.

State DRAIN:
- pc_en=0, ifid_en=0.
- idex_flush = ifid_flush = back_go.
- exmem_en = memwb_en = back_go.
- Each back_go increments drain_cnt.
- When drain_cnt==BACK_STAGES-1 and back_go: go to HALTED and set halt=1 on the same edge.

State HALTED:
- All enables 0, halt=1.
- Remains until RST.

Stall counter:
- stall_cnt increments by 1 per cycle in RUN when (mem_req && !dhit) or (load_use && back_go).
- Saturates at 2^CNT_W-1.
- Never counts in DRAIN or HALTED.

Simultaneous events:
- Store (mem_dWEN) with dhit low: back_go=0, everything frozen, regardless of ihit.

Test Plan:
- Forwarding: mem_WEN=1, mem_wsel=5, mem_port_o=0xAAAA; wb_WEN=1, wb_wsel=5, wb_wdat=0xBBBB; ex_rsel[0]=5 -> fwd_rdat[0]=0xAAAA. Set mem_WEN=0 -> 0xBBBB. Set ex_rsel=0 -> 0.
- Load-use: ex_dREN=ex_WEN=1, ex_wsel=3, id_rsel[1]=3, id_valid=1, ihit=1 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cnt 0->1; the next cycle resumes normal advance.
- Dcache wait: mem_dREN=1, dhit low 4 cycles then high -> all enables 0 for 4 cycles, stall_cnt=4, then a cycle with all back enables 1.
- Branch plus load-use together: branch_taken=1 with load_use=1, ihit=1 -> pc_en=1, ifid_flush=1, idex_flush=1, stall_cnt unchanged.
- Halt drain: ex_halt=1 with ihit=1 -> DRAIN. After 2 further back_go cycles -> halt=1 and all enables 0 indefinitely. Assert RST one cycle -> halt=0, state RUN.
- Counter saturation: CNT_W=4, hold mem_dREN with dhit=0 for 20 cycles -> stall_cnt sticks at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Control bundle between the hazard controller and the 5-stage datapath.
// The datapath drives stage status in and receives latch enables/flushes and forwarded operands.
interface pipe_hazard_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int REGS_W = 5,
  parameter int NRD    = 2,
  parameter int CNT_W  = 16
);
  logic                          ihit, dhit, id_valid;
  logic [NRD-1:0][REGS_W-1:0]    id_rsel, ex_rsel;
  logic [NRD-1:0][DATA_W-1:0]    ex_rdat;
  logic                          ex_dREN, ex_WEN, ex_halt, branch_taken;
  logic [REGS_W-1:0]             ex_wsel, mem_wsel, wb_wsel;
  logic                          mem_dREN, mem_dWEN, mem_WEN, wb_WEN;
  logic [DATA_W-1:0]             mem_port_o, wb_wdat;
  logic [NRD-1:0][DATA_W-1:0]    fwd_rdat;
  logic                          pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic                          exmem_en, memwb_en, halt;
  logic [CNT_W-1:0]              stall_cnt;

  modport slave (
    input  ihit, dhit, id_valid, id_rsel, ex_rsel, ex_rdat, ex_dREN, ex_WEN, ex_wsel,
           ex_halt, branch_taken, mem_dREN, mem_dWEN, mem_WEN, mem_wsel, mem_port_o,
           wb_WEN, wb_wsel, wb_wdat,
    output fwd_rdat, pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
           halt, stall_cnt
  );

  modport master (
    output ihit, dhit, id_valid, id_rsel, ex_rsel, ex_rdat, ex_dREN, ex_WEN, ex_wsel,
           ex_halt, branch_taken, mem_dREN, mem_dWEN, mem_WEN, mem_wsel, mem_port_o,
           wb_WEN, wb_wsel, wb_wdat,
    input  fwd_rdat, pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
           halt, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding/pipe-enable controller for the IF-ID-EX-MEM-WB core.
// One forwarding mux per read port; a RUN/DRAIN/HALTED FSM owns every latch enable.
module pipe_hazard_fwd #(
  parameter int DATA_W = 32,
  parameter int REGS_W = 5
)(
  input  logic [REGS_W-1:0] i_rsel,
  input  logic [DATA_W-1:0] i_rdat,
  input  logic              i_mem_fwd,
  input  logic [REGS_W-1:0] i_mem_wsel,
  input  logic [DATA_W-1:0] i_mem_dat,
  input  logic              i_wb_fwd,
  input  logic [REGS_W-1:0] i_wb_wsel,
  input  logic [DATA_W-1:0] i_wb_dat,
  output logic [DATA_W-1:0] o_rdat
);
  // Younger producer (MEM) wins over WB; r0 is hardwired zero.
  always_comb begin
    if (i_rsel == '0)                           o_rdat = '0;
    else if (i_mem_fwd && i_mem_wsel == i_rsel) o_rdat = i_mem_dat;
    else if (i_wb_fwd && i_wb_wsel == i_rsel)   o_rdat = i_wb_dat;
    else                                        o_rdat = i_rdat;
  end
endmodule

module pipe_hazard_ctrl #(
  parameter int DATA_W      = 32,
  parameter int REGS_W      = 5,
  parameter int NRD         = 2,
  parameter int BACK_STAGES = 2,
  parameter int CNT_W       = 16
)(
  input logic               CLK,
  input logic               RST,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int DC_W = (BACK_STAGES > 1) ? $clog2(BACK_STAGES) : 1;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t                    r_state, w_state_nxt;
  logic [DC_W-1:0]           r_drain_cnt;
  logic                      r_halt;
  logic [CNT_W-1:0]          r_stall_cnt;
  logic                      w_mem_req, w_back_go, w_rsel_hit, w_load_use;
  logic                      w_drain_last, w_cnt_inc;
  logic [NRD-1:0][DATA_W-1:0] w_fwd;

  for (genvar p = 0; p < NRD; p++) begin : g_fwd
    pipe_hazard_fwd #(.DATA_W(DATA_W), .REGS_W(REGS_W)) u_fwd (
      .i_rsel    (bus.ex_rsel[p]),
      .i_rdat    (bus.ex_rdat[p]),
      .i_mem_fwd (bus.mem_WEN && !bus.mem_dREN),
      .i_mem_wsel(bus.mem_wsel),
      .i_mem_dat (bus.mem_port_o),
      .i_wb_fwd  (bus.wb_WEN),
      .i_wb_wsel (bus.wb_wsel),
      .i_wb_dat  (bus.wb_wdat),
      .o_rdat    (w_fwd[p])
    );
  end
  assign bus.fwd_rdat = w_fwd;

  always_comb begin
    w_mem_req  = bus.mem_dREN | bus.mem_dWEN;
    w_back_go  = w_mem_req ? bus.dhit : bus.ihit;
    w_rsel_hit = 1'b0;
    for (int p = 0; p < NRD; p++)
      if (bus.id_rsel[p] == bus.ex_wsel) w_rsel_hit = 1'b1;
    w_load_use = bus.id_valid && bus.ex_dREN && bus.ex_WEN && (bus.ex_wsel != '0) && w_rsel_hit;
    w_drain_last = (r_drain_cnt == DC_W'(BACK_STAGES-1));
    // A load-use that loses to a taken branch never stalls, so it is not counted.
    w_cnt_inc  = (r_state == RUN) &&
                 ((w_mem_req && !bus.dhit) || (w_load_use && w_back_go && !bus.branch_taken));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= RUN;
      r_drain_cnt <= '0;
      r_halt      <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == RUN && w_state_nxt == DRAIN)  r_drain_cnt <= '0;
      else if (r_state == DRAIN && w_back_go)      r_drain_cnt <= r_drain_cnt + 1'b1;
      if (r_state == DRAIN && w_state_nxt == HALTED) r_halt <= 1'b1;
      if (w_cnt_inc && r_stall_cnt != '1)          r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (bus.ex_halt && w_back_go && !bus.branch_taken) w_state_nxt = DRAIN;
      DRAIN:   if (w_back_go && w_drain_last)                     w_state_nxt = HALTED;
      HALTED:  w_state_nxt = HALTED;
      default: w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    bus.pc_en      = 1'b0;
    bus.ifid_en    = 1'b0;
    bus.ifid_flush = 1'b0;
    bus.idex_en    = 1'b0;
    bus.idex_flush = 1'b0;
    bus.exmem_en   = 1'b0;
    bus.memwb_en   = 1'b0;
    if (!RST) begin
      case (r_state)
        RUN: begin
          bus.idex_en  = w_back_go;
          bus.exmem_en = w_back_go;
          bus.memwb_en = w_back_go;
          if (bus.branch_taken && w_back_go) begin
            bus.pc_en      = 1'b1;
            bus.ifid_flush = 1'b1;
            bus.idex_flush = 1'b1;
          end else if (w_load_use && w_back_go) begin
            bus.idex_flush = 1'b1;
          end else begin
            bus.pc_en      = bus.ihit && w_back_go;
            bus.ifid_en    = bus.ihit && w_back_go;
            bus.ifid_flush = w_back_go && !bus.ihit;
          end
        end
        DRAIN: begin
          // ID/EX loads bubbles behind the halt while the back end empties.
          bus.idex_en    = w_back_go;
          bus.idex_flush = w_back_go;
          bus.ifid_flush = w_back_go;
          bus.exmem_en   = w_back_go;
          bus.memwb_en   = w_back_go;
        end
        default: ;
      endcase
    end
  end

  assign bus.halt      = r_halt;
  assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: driver queues expected outputs per cycle, a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;
  localparam logic [6:0] EN_NONE  = 7'b0000000;
  localparam logic [6:0] EN_RUN   = 7'b1101011;
  localparam logic [6:0] EN_LU    = 7'b0001111;
  localparam logic [6:0] EN_BR    = 7'b1011111;
  localparam logic [6:0] EN_IMISS = 7'b0011011;
  localparam logic [6:0] EN_DRN   = 7'b0010111;
  localparam logic [6:0] M_ALL    = 7'b1111111;
  localparam logic [6:0] M_DRN    = 7'b1110111;

  typedef struct {
    string       name;
    logic [6:0]  en;
    logic [6:0]  msk;
    logic        halt;
    logic [3:0]  cnt;
    logic        chk_fwd;
    logic [31:0] f0, f1;
  } exp_t;

  logic CLK, RST;
  exp_t q[$];
  int   checks = 0, failures = 0;
  logic [6:0] en_now;

  pipe_hazard_ctrl_if #(.DATA_W(32), .REGS_W(5), .NRD(2), .CNT_W(4)) bus();
  pipe_hazard_ctrl #(.DATA_W(32), .REGS_W(5), .NRD(2), .BACK_STAGES(2), .CNT_W(4)) u_dut (
    .CLK(CLK), .RST(RST), .bus(bus.slave));

  assign en_now = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_flush,
                   bus.exmem_en, bus.memwb_en};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (((en_now ^ e.en) & e.msk) != 7'b0) begin
        failures++;
        $display("FAIL %s enables got=%b want=%b mask=%b", e.name, en_now, e.en, e.msk);
      end
      checks++;
      if (bus.halt !== e.halt) begin
        failures++;
        $display("FAIL %s halt got=%b want=%b", e.name, bus.halt, e.halt);
      end
      checks++;
      if (bus.stall_cnt !== e.cnt) begin
        failures++;
        $display("FAIL %s stall_cnt got=%0d want=%0d", e.name, bus.stall_cnt, e.cnt);
      end
      if (e.chk_fwd) begin
        checks++;
        if (bus.fwd_rdat[0] !== e.f0 || bus.fwd_rdat[1] !== e.f1) begin
          failures++;
          $display("FAIL %s fwd got=%h/%h want=%h/%h", e.name,
                   bus.fwd_rdat[0], bus.fwd_rdat[1], e.f0, e.f1);
        end
      end
    end
  end

  task automatic exp_out(input string n, input logic [6:0] en, input logic [6:0] msk,
                         input logic h, input logic [3:0] c);
    exp_t e;
    e.name = n; e.en = en; e.msk = msk; e.halt = h; e.cnt = c;
    e.chk_fwd = 1'b0; e.f0 = '0; e.f1 = '0;
    q.push_back(e);
  endtask

  task automatic exp_fwd(input string n, input logic [3:0] c, input logic [31:0] f0,
                         input logic [31:0] f1);
    exp_t e;
    e.name = n; e.en = EN_RUN; e.msk = M_ALL; e.halt = 1'b0; e.cnt = c;
    e.chk_fwd = 1'b1; e.f0 = f0; e.f1 = f1;
    q.push_back(e);
  endtask

  task automatic tick;
    @(posedge CLK); #1;
  endtask

  task automatic idle;
    bus.ihit = 1'b1; bus.dhit = 1'b1; bus.id_valid = 1'b0;
    bus.id_rsel = '0; bus.ex_rsel = '0;
    bus.ex_rdat[0] = 32'h1111; bus.ex_rdat[1] = 32'h2222;
    bus.ex_dREN = 1'b0; bus.ex_WEN = 1'b0; bus.ex_wsel = '0; bus.ex_halt = 1'b0;
    bus.branch_taken = 1'b0; bus.mem_dREN = 1'b0; bus.mem_dWEN = 1'b0;
    bus.mem_WEN = 1'b0; bus.mem_wsel = '0; bus.mem_port_o = '0;
    bus.wb_WEN = 1'b0; bus.wb_wsel = '0; bus.wb_wdat = '0;
  endtask

  task automatic set_load_use;
    bus.ex_dREN = 1'b1; bus.ex_WEN = 1'b1; bus.ex_wsel = 5'd3;
    bus.id_valid = 1'b1; bus.id_rsel[0] = 5'd1; bus.id_rsel[1] = 5'd3;
  endtask

  initial begin
    RST = 1'b1; idle();
    tick();
    exp_out("reset", EN_NONE, M_ALL, 1'b0, 4'd0);
    tick();
    RST = 1'b0;

    // forwarding priority
    bus.mem_WEN = 1'b1; bus.mem_wsel = 5'd5; bus.mem_port_o = 32'hAAAA;
    bus.wb_WEN = 1'b1; bus.wb_wsel = 5'd5; bus.wb_wdat = 32'hBBBB;
    bus.ex_rsel[0] = 5'd5; bus.ex_rsel[1] = 5'd7;
    exp_fwd("fwd_mem", 4'd0, 32'hAAAA, 32'h2222); tick();
    bus.mem_WEN = 1'b0;
    exp_fwd("fwd_wb", 4'd0, 32'hBBBB, 32'h2222); tick();
    bus.mem_WEN = 1'b1; bus.mem_dREN = 1'b1;
    exp_fwd("fwd_mem_load", 4'd0, 32'hBBBB, 32'h2222); tick();
    bus.mem_dREN = 1'b0; bus.mem_wsel = 5'd0; bus.ex_rsel[0] = 5'd0;
    bus.ex_rsel[1] = 5'd5; bus.mem_wsel = 5'd9;
    exp_fwd("fwd_r0", 4'd0, 32'h0, 32'hBBBB); tick();
    idle();

    // load-use bubble
    set_load_use();
    exp_out("lu_stall", EN_LU, M_ALL, 1'b0, 4'd0); tick();
    bus.ex_dREN = 1'b0;
    exp_out("lu_resume", EN_RUN, M_ALL, 1'b0, 4'd1); tick();
    set_load_use(); bus.ex_wsel = 5'd0; bus.id_rsel = '0;
    exp_out("lu_r0", EN_RUN, M_ALL, 1'b0, 4'd1); tick();
    idle();

    // dcache wait
    bus.mem_dREN = 1'b1; bus.dhit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_out("dmiss", EN_NONE, M_ALL, 1'b0, 4'(1 + i)); tick();
    end
    bus.dhit = 1'b1;
    exp_out("dhit", EN_RUN, M_ALL, 1'b0, 4'd5); tick();
    bus.ihit = 1'b0;
    exp_out("dhit_imiss", EN_IMISS, M_ALL, 1'b0, 4'd5); tick();
    idle(); bus.mem_dWEN = 1'b1; bus.dhit = 1'b0;
    exp_out("store_miss", EN_NONE, M_ALL, 1'b0, 4'd5); tick();
    idle(); bus.ihit = 1'b0;
    exp_out("imiss", EN_NONE, M_ALL, 1'b0, 4'd6); tick();
    idle();
    exp_out("after_imiss", EN_RUN, M_ALL, 1'b0, 4'd6); tick();

    // branch beats load-use
    set_load_use(); bus.branch_taken = 1'b1;
    exp_out("br_lu", EN_BR, M_ALL, 1'b0, 4'd6); tick();
    idle();
    exp_out("br_after", EN_RUN, M_ALL, 1'b0, 4'd6); tick();

    // halt drain
    bus.ex_halt = 1'b1;
    exp_out("halt_ex", EN_RUN, M_ALL, 1'b0, 4'd6); tick();
    bus.ex_halt = 1'b0;
    exp_out("drain1", EN_DRN, M_DRN, 1'b0, 4'd6); tick();
    bus.mem_dREN = 1'b1; bus.dhit = 1'b0;
    exp_out("drain_wait", EN_NONE, M_ALL, 1'b0, 4'd6); tick();
    idle();
    exp_out("drain2", EN_DRN, M_DRN, 1'b0, 4'd6); tick();
    bus.mem_dREN = 1'b1; bus.dhit = 1'b0; bus.ex_halt = 1'b1; bus.branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_out("halted", EN_NONE, M_ALL, 1'b1, 4'd6); tick();
    end
    idle(); RST = 1'b1;
    exp_out("rst_halted", EN_NONE, M_ALL, 1'b1, 4'd6); tick();
    RST = 1'b0;
    exp_out("post_rst", EN_RUN, M_ALL, 1'b0, 4'd0); tick();

    // counter saturation
    bus.mem_dREN = 1'b1; bus.dhit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      exp_out("sat", EN_NONE, M_ALL, 1'b0, (i > 15) ? 4'd15 : 4'(i)); tick();
    end
    idle();
    exp_out("sat_hold", EN_RUN, M_ALL, 1'b0, 4'd15); tick();
    exp_out("sat_hold2", EN_RUN, M_ALL, 1'b0, 4'd15); tick();

    @(negedge CLK); #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain_queue left=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end
endmodule
